// File: rtl/music_player_param.sv
// music_player_param: parametrised song sequencer.
// Fetches note words for the selected song from word memory, holds each note for a per-word or
// global duration and routes the matching free-running tone generator to the speaker output.
// Build option: define MUSIC_PLAYER_LOOP_EN to honour the loop input at the end-of-song marker.
module music_player_param #(
  parameter int unsigned NUM_NOTES  = 7,
  parameter int unsigned PERIOD_W   = 8,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned SONG_BYTES = 512,
  localparam int unsigned NS_W      = $clog2(NUM_NOTES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              song_sel,
  input  logic                          start_song,
  input  logic                          pause,
  input  logic                          loop,
  input  logic [DUR_W-1:0]              note_duration,
  input  logic [NUM_NOTES*PERIOD_W-1:0] note_periods,
  output logic [2:0]                    state,
  output logic                          idle,
  output logic [NS_W-1:0]               note_sel,
  output logic                          note,
  output logic                          memreq_val,
  output logic [15:0]                   memreq_addr,
  input  logic                          memresp_wait,
  input  logic [31:0]                   memresp_data
);

  localparam int unsigned IDX_W  = $clog2(SONG_BYTES / 4);
  localparam int unsigned BASE_SH = $clog2(SONG_BYTES);

  typedef enum logic [2:0] {
    StReset = 3'd0,
    StIdle  = 3'd1,
    StFetch = 3'd2,
    StWait  = 3'd3,
    StPause = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [NS_W-1:0]    note_sel_q, note_sel_d;

  logic [NUM_NOTES:1] tone_vec;
  logic [(2**NS_W)-1:0] tone_all;
  logic [31:0]        base_full;
  logic [NS_W-1:0]    word_sel;
  logic [DUR_W-1:0]   word_dur;
  logic               end_marker;

  // One tone generator per note; free-running from reset and never re-phased by the sequencer.
  // A half-period of P cycles toggles the tone every P cycles; P = 0 keeps that tone silent.
  for (genvar k = 1; k <= NUM_NOTES; k++) begin : g_tone
    logic [PERIOD_W-1:0] per;
    logic [PERIOD_W-1:0] tcnt_q;
    logic                tone_q;

    assign per         = note_periods[k*PERIOD_W-1 -: PERIOD_W];
    assign tone_vec[k] = tone_q;

    // Half-period counter and tone toggle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tcnt_q <= '0;
        tone_q <= 1'b0;
      end else if (per == '0) begin
        tcnt_q <= '0;
        tone_q <= 1'b0;
      end else if (tcnt_q >= per - PERIOD_W'(1)) begin
        tcnt_q <= '0;
        tone_q <= ~tone_q;
      end else begin
        tcnt_q <= tcnt_q + PERIOD_W'(1);
      end
    end
  end

  assign base_full   = 32'(song_sel) << BASE_SH;
  assign word_sel    = memresp_data[NS_W-1:0];
  assign word_dur    = memresp_data[16 +: DUR_W];
  assign end_marker  = (memresp_data == 32'hFFFF_FFFF);

`ifndef MUSIC_PLAYER_LOOP_EN
  // Loop requests have no effect in this build.
  logic unused_loop;
  assign unused_loop = loop;
`endif

  // Sequencer next-state: song start, note fetch/decode, duration countdown and pause.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    note_sel_d = note_sel_q;
    unique case (state_q)
      StReset: begin
        state_d = StIdle;
      end
      StIdle: begin
        note_sel_d = '0;
        if (start_song) begin
          base_d  = base_full[15:0];
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        note_sel_d = '0;
        if (!memresp_wait) begin
          if (end_marker) begin
`ifdef MUSIC_PLAYER_LOOP_EN
            if (loop) begin
              idx_d = '0;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end else begin
            // Out-of-range note codes play as a rest.
            note_sel_d = (32'(word_sel) > NUM_NOTES) ? '0 : word_sel;
            cnt_d      = (word_dur == '0) ? note_duration : word_dur;
            idx_d      = idx_q + IDX_W'(1);
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        // Pause wins over the end-of-note exit so a paused note never loses its last cycle.
        if (pause) begin
          state_d = StPause;
        end else if (cnt_q == '0) begin
          note_sel_d = '0;
          state_d    = StFetch;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      StPause: begin
        if (!pause) begin
          state_d = StWait;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StReset;
      base_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      note_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      note_sel_q <= note_sel_d;
    end
  end

  // Output routing: tone only while a note is counting and pause is low.
  always_comb begin
    tone_all              = '0;
    tone_all[NUM_NOTES:1] = tone_vec;
    note                  = 1'b0;
    if (state_q == StWait && !pause) begin
      note = tone_all[note_sel_q];
    end
  end

  assign state       = state_q;
  assign idle        = (state_q == StIdle);
  assign note_sel    = note_sel_q;
  assign memreq_val  = (state_q == StFetch);
  assign memreq_addr = base_q + 16'({idx_q, 2'b00});

endmodule
